// File: rtl/block_sched_pkg.sv
// Shared types and widths for the obstacle-column scheduler.
package block_sched_pkg;

  localparam int unsigned X_W     = 13;
  localparam int unsigned FREQ_W  = 16;
  localparam int unsigned NOTE_W  = 8;
  localparam int unsigned SPEED_W = 4;
  localparam int unsigned SCORE_W = 16;
  // One sign bit over X_W so edge arithmetic can go below zero safely
  localparam int unsigned CALC_W  = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SPAWN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic              active;
    logic [X_W-1:0]    x;
    logic [FREQ_W-1:0] freq;
    logic [NOTE_W-1:0] note;
  } slot_t;

endpackage

// File: rtl/block_slot.sv
// One obstacle column: holds position and latched pitch, scrolls, retires
// and flags the frame in which its right edge passes the player.
module block_slot
  import block_sched_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH = 1280,
  parameter int unsigned BLOCK_WIDTH  = 32,
  parameter int unsigned PLAYER_X     = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_move,
  input  logic               i_spawn,
  input  logic [SPEED_W-1:0] i_speed,
  input  logic [FREQ_W-1:0]  i_freq,
  input  logic [NOTE_W-1:0]  i_note,
  output slot_t              o_slot,
  output logic               o_score_hit_c
);

  slot_t                    r_slot;
  logic signed [CALC_W-1:0] w_right;
  logic signed [CALC_W-1:0] w_next_right;
  logic signed [CALC_W-1:0] w_player;
  logic                     w_retire;

  assign w_right      = $signed(CALC_W'(r_slot.x)) + $signed(CALC_W'(BLOCK_WIDTH));
  assign w_next_right = w_right - $signed(CALC_W'(i_speed));
  assign w_player     = $signed(CALC_W'(PLAYER_X));
  assign w_retire     = r_slot.x < X_W'(i_speed);

  assign o_score_hit_c = i_move && r_slot.active
                         && (w_right > w_player) && (w_next_right <= w_player);
  assign o_slot        = r_slot;

  // A retiring column keeps its last x/freq/note; only the valid bit drops
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot <= '0;
    end else if (i_spawn) begin
      r_slot <= '{active: 1'b1, x: X_W'(SCREEN_WIDTH), freq: i_freq, note: i_note};
    end else if (i_move && r_slot.active) begin
      if (w_retire) begin
        r_slot.active <= 1'b0;
      end else begin
        r_slot.x <= r_slot.x - X_W'(i_speed);
      end
    end
  end

endmodule

// File: rtl/block_scheduler.sv
// Per-frame controller for the scrolling obstacle columns: walks the slots
// one per cycle, then spawns into the lowest free slot every SPAWN_PERIOD frames.
module block_scheduler
  import block_sched_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS   = 4,
  parameter int unsigned SCREEN_WIDTH = 1280,
  parameter int unsigned BLOCK_WIDTH  = 32,
  parameter int unsigned SPAWN_PERIOD = 90,
  parameter int unsigned PLAYER_X     = 200
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         game_en,
  input  logic                         frame_tick,
  input  logic [SPEED_W-1:0]           speed_in,
  input  logic [FREQ_W-1:0]            freq_in,
  input  logic [NOTE_W-1:0]            true_note,
  output logic [NUM_BLOCKS*X_W-1:0]    block_x_out,
  output logic [NUM_BLOCKS*FREQ_W-1:0] block_freq_out,
  output logic [NUM_BLOCKS*NOTE_W-1:0] block_note_out,
  output logic [NUM_BLOCKS-1:0]        block_active_out,
  output logic [SCORE_W-1:0]           score_out,
  output logic                         busy_out,
  output logic                         update_done,
  output logic                         overrun_out,
  output logic                         spawn_drop
);

  localparam int unsigned IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int unsigned CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [CNT_W-1:0]     r_spawn_cnt;
  logic [CNT_W-1:0]     w_spawn_cnt_nxt;
  logic [SCORE_W-1:0]   r_score;
  logic [SCORE_W-1:0]   w_score_nxt;
  logic                 r_busy;
  logic                 w_busy_nxt;
  logic                 r_update_done;
  logic                 w_update_done_nxt;
  logic                 r_overrun;
  logic                 w_overrun_nxt;
  logic                 r_spawn_drop;
  logic                 w_spawn_drop_nxt;

  logic [NUM_BLOCKS-1:0] w_move;
  logic [NUM_BLOCKS-1:0] w_spawn;
  logic [NUM_BLOCKS-1:0] w_hit;
  logic [NUM_BLOCKS-1:0] w_active;
  logic [NUM_BLOCKS-1:0] w_free_onehot;
  logic                  w_free_any;
  slot_t                 w_slot [NUM_BLOCKS];

  for (genvar g = 0; g < NUM_BLOCKS; g++) begin : g_slot
    block_slot #(
      .SCREEN_WIDTH (SCREEN_WIDTH),
      .BLOCK_WIDTH  (BLOCK_WIDTH),
      .PLAYER_X     (PLAYER_X)
    ) u_slot (
      .clk           (clk),
      .rst           (rst),
      .i_move        (w_move[g]),
      .i_spawn       (w_spawn[g]),
      .i_speed       (speed_in),
      .i_freq        (freq_in),
      .i_note        (true_note),
      .o_slot        (w_slot[g]),
      .o_score_hit_c (w_hit[g])
    );

    assign w_active[g]                       = w_slot[g].active;
    assign block_active_out[g]               = w_slot[g].active;
    assign block_x_out[g*X_W +: X_W]         = w_slot[g].x;
    assign block_freq_out[g*FREQ_W +: FREQ_W] = w_slot[g].freq;
    assign block_note_out[g*NOTE_W +: NOTE_W] = w_slot[g].note;
  end

  // Lowest-index inactive slot wins the spawn
  always_comb begin
    w_free_onehot = '0;
    w_free_any    = 1'b0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      if (!w_active[i] && !w_free_any) begin
        w_free_onehot[i] = 1'b1;
        w_free_any       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_spawn_cnt   <= '0;
      r_score       <= '0;
      r_busy        <= 1'b0;
      r_update_done <= 1'b0;
      r_overrun     <= 1'b0;
      r_spawn_drop  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_spawn_cnt   <= w_spawn_cnt_nxt;
      r_score       <= w_score_nxt;
      r_busy        <= w_busy_nxt;
      r_update_done <= w_update_done_nxt;
      r_overrun     <= w_overrun_nxt;
      r_spawn_drop  <= w_spawn_drop_nxt;
    end
  end

  // Pulses and busy are decoded from the upcoming state so they line up with it
  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_spawn_cnt_nxt   = r_spawn_cnt;
    w_score_nxt       = r_score;
    w_busy_nxt        = 1'b0;
    w_update_done_nxt = 1'b0;
    w_overrun_nxt     = frame_tick && (r_state != IDLE);
    w_spawn_drop_nxt  = 1'b0;
    w_move            = '0;
    w_spawn           = '0;

    if ((|w_hit) && (r_score != '1)) begin
      w_score_nxt = r_score + SCORE_W'(1);
    end

    case (r_state)
      IDLE: begin
        if (frame_tick && game_en) begin
          w_state_nxt = SCAN;
          w_idx_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      SCAN: begin
        w_busy_nxt    = 1'b1;
        w_move[r_idx] = 1'b1;
        if (r_idx == IDX_W'(NUM_BLOCKS - 1)) begin
          w_state_nxt = SPAWN;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      SPAWN: begin
        w_state_nxt       = DONE;
        w_update_done_nxt = 1'b1;
        if (r_spawn_cnt == CNT_W'(SPAWN_PERIOD - 1)) begin
          w_spawn_cnt_nxt = '0;
          if (w_free_any) begin
            w_spawn = w_free_onehot;
          end else begin
            w_spawn_drop_nxt = 1'b1;
          end
        end else begin
          w_spawn_cnt_nxt = r_spawn_cnt + CNT_W'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign score_out   = r_score;
  assign busy_out    = r_busy;
  assign update_done = r_update_done;
  assign overrun_out = r_overrun;
  assign spawn_drop  = r_spawn_drop;

endmodule

// File: tb/tb_block_scheduler.sv
// Directed bench for block_scheduler with SPAWN_PERIOD = 3.
module tb_block_scheduler;

  localparam int unsigned NB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            game_en;
  logic            frame_tick;
  logic [3:0]      speed_in;
  logic [15:0]     freq_in;
  logic [7:0]      true_note;
  logic [NB*13-1:0] block_x_out;
  logic [NB*16-1:0] block_freq_out;
  logic [NB*8-1:0]  block_note_out;
  logic [NB-1:0]    block_active_out;
  logic [15:0]     score_out;
  logic            busy_out;
  logic            update_done;
  logic            overrun_out;
  logic            spawn_drop;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat;
  int   busy_cnt;
  logic drop_seen;
  int   n_done;
  int   n_over;
  int   n_busy;

  block_scheduler #(
    .NUM_BLOCKS   (NB),
    .SCREEN_WIDTH (1280),
    .BLOCK_WIDTH  (32),
    .SPAWN_PERIOD (3),
    .PLAYER_X     (200)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .game_en          (game_en),
    .frame_tick       (frame_tick),
    .speed_in         (speed_in),
    .freq_in          (freq_in),
    .true_note        (true_note),
    .block_x_out      (block_x_out),
    .block_freq_out   (block_freq_out),
    .block_note_out   (block_note_out),
    .block_active_out (block_active_out),
    .score_out        (score_out),
    .busy_out         (busy_out),
    .update_done      (update_done),
    .overrun_out      (overrun_out),
    .spawn_drop       (spawn_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [12:0] slot_x(input int i);
    return block_x_out[13*i +: 13];
  endfunction

  function automatic logic [15:0] slot_f(input int i);
    return block_freq_out[16*i +: 16];
  endfunction

  function automatic logic [7:0] slot_n(input int i);
    return block_note_out[8*i +: 8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One frame update; optionally drops game_en two cycles into the update
  task automatic run_tick(input logic [3:0] spd, input logic [15:0] f,
                          input logic [7:0] n, input logic en_fall);
    @(negedge clk);
    speed_in   = spd;
    freq_in    = f;
    true_note  = n;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    lat        = 1;
    busy_cnt   = 0;
    drop_seen  = 1'b0;
    while (!update_done && lat < 20) begin
      if (busy_out) busy_cnt++;
      if (spawn_drop) drop_seen = 1'b1;
      if (en_fall && lat == 2) game_en = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (spawn_drop) drop_seen = 1'b1;
    chk("update_latency", lat, 6);
    chk("busy_cycles", busy_cnt, 5);
  endtask

  // Pulse frame_tick and watch a fixed window for any activity
  task automatic idle_window(input int cycles);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    n_done = 0;
    n_over = 0;
    n_busy = 0;
    for (int c = 0; c < cycles; c++) begin
      if (update_done) n_done++;
      if (overrun_out) n_over++;
      if (busy_out) n_busy++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst        = 1'b1;
    game_en    = 1'b0;
    frame_tick = 1'b0;
    speed_in   = 4'd0;
    freq_in    = 16'h0;
    true_note  = 8'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_active", block_active_out, 0);
    chk("rst_x", block_x_out, 0);
    chk("rst_freq", block_freq_out, 0);
    chk("rst_note", block_note_out, 0);
    chk("rst_score", score_out, 0);
    chk("rst_pulses", {busy_out, update_done, overrun_out, spawn_drop}, 0);

    // Tick with game disabled is ignored entirely
    idle_window(10);
    chk("dis_busy", n_busy, 0);
    chk("dis_done", n_done, 0);
    chk("dis_overrun", n_over, 0);

    // Spawn on the third frame
    game_en = 1'b1;
    run_tick(4'd4, 16'h0190, 8'h2A, 1'b0);
    run_tick(4'd4, 16'h0190, 8'h2A, 1'b0);
    chk("pre_spawn_active", block_active_out, 0);
    run_tick(4'd4, 16'h0190, 8'h2A, 1'b0);
    chk("spawn_active", block_active_out, 4'b0001);
    chk("spawn_x0", slot_x(0), 1280);
    chk("spawn_f0", slot_f(0), 16'h0190);
    chk("spawn_n0", slot_n(0), 8'h2A);

    // Scroll ten frames; slots 1..3 fill at frames 6, 9, 12
    for (int k = 4; k <= 13; k++) begin
      run_tick(4'd4, 16'h1000 + 16'(k), 8'(k), 1'b0);
      chk("fill_no_drop", drop_seen, 0);
    end
    chk("scroll_x0", slot_x(0), 1240);
    chk("scroll_x1", slot_x(1), 1252);
    chk("scroll_x2", slot_x(2), 1264);
    chk("scroll_x3", slot_x(3), 1276);
    chk("scroll_active", block_active_out, 4'b1111);
    chk("scroll_f1", slot_f(1), 16'h1006);
    chk("scroll_n3", slot_n(3), 8'h0C);

    // Full: spawn due at frame 15 is dropped, slots untouched apart from scrolling
    run_tick(4'd4, 16'h100E, 8'h0E, 1'b0);
    chk("full_no_drop14", drop_seen, 0);
    run_tick(4'd4, 16'h100F, 8'h0F, 1'b0);
    chk("full_drop15", drop_seen, 1);
    chk("full_x0", slot_x(0), 1232);
    chk("full_x3", slot_x(3), 1268);
    chk("full_f0", slot_f(0), 16'h0190);
    chk("full_score", score_out, 0);

    // Fast scroll; drop attempts every third frame
    for (int k = 16; k <= 85; k++) begin
      run_tick(4'd15, 16'h1000 + 16'(k), 8'(k), 1'b0);
      chk("drop_period", drop_seen, (k % 3 == 0));
    end
    run_tick(4'd10, 16'h1056, 8'h56, 1'b0);
    chk("approach_x0", slot_x(0), 172);
    chk("approach_score", score_out, 0);

    // Slot0 right edge 204 -> 200 crosses the player
    run_tick(4'd4, 16'h1057, 8'h57, 1'b0);
    chk("cross_x0", slot_x(0), 168);
    chk("cross_score", score_out, 1);
    run_tick(4'd4, 16'h1058, 8'h58, 1'b0);
    chk("past_x0", slot_x(0), 164);
    chk("past_score", score_out, 1);
    chk("past_x3", slot_x(3), 200);

    // Slots 1..3 cross during frames 89..91
    for (int k = 89; k <= 98; k++) begin
      run_tick(4'd15, 16'h1000 + 16'(k), 8'(k), 1'b0);
    end
    chk("multi_score", score_out, 4);
    chk("multi_x0", slot_x(0), 14);
    chk("multi_x3", slot_x(3), 50);
    run_tick(4'd11, 16'h1063, 8'h63, 1'b0);
    chk("edge_x0", slot_x(0), 3);
    chk("edge_active", block_active_out, 4'b1111);

    // Zero speed frame with a second tick two cycles in
    speed_in = 4'd0;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    n_done = 0;
    n_over = 0;
    for (int c = 0; c < 16; c++) begin
      if (update_done) n_done++;
      if (overrun_out) n_over++;
      frame_tick = (c == 1);
      @(negedge clk);
    end
    frame_tick = 1'b0;
    chk("overrun_pulses", n_over, 1);
    chk("overrun_done_once", n_done, 1);
    chk("zero_speed_x0", slot_x(0), 3);
    chk("zero_speed_x1", slot_x(1), 15);
    chk("zero_speed_active", block_active_out, 4'b1111);

    // x = 3 with speed 4 retires, position held
    run_tick(4'd4, 16'h1065, 8'h65, 1'b0);
    chk("retire_active", block_active_out, 4'b1110);
    chk("retire_x0", slot_x(0), 3);
    chk("retire_f0", slot_f(0), 16'h0190);
    chk("retire_x1", slot_x(1), 11);

    // Counter restarted at frame 99, so frame 102 spawns into freed slot0
    run_tick(4'd4, 16'hBEEF, 8'h66, 1'b0);
    chk("respawn_active", block_active_out, 4'b1111);
    chk("respawn_x0", slot_x(0), 1280);
    chk("respawn_f0", slot_f(0), 16'hBEEF);
    chk("respawn_n0", slot_n(0), 8'h66);
    chk("respawn_x1", slot_x(1), 7);
    chk("respawn_drop", drop_seen, 0);
    chk("respawn_score", score_out, 4);

    // game_en falling mid-update: update still completes
    run_tick(4'd4, 16'h1067, 8'h67, 1'b1);
    chk("enfall_x0", slot_x(0), 1276);
    chk("enfall_x1", slot_x(1), 3);
    idle_window(10);
    chk("enoff_busy", n_busy, 0);
    chk("enoff_done", n_done, 0);
    chk("enoff_x0", slot_x(0), 1276);

    // Reset during SCAN
    game_en = 1'b1;
    speed_in = 4'd4;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("pre_rst_busy", busy_out, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_active", block_active_out, 0);
    chk("midrst_x", block_x_out, 0);
    chk("midrst_freq", block_freq_out, 0);
    chk("midrst_score", score_out, 0);
    chk("midrst_pulses", {busy_out, update_done, overrun_out, spawn_drop}, 0);
    n_done = 0;
    for (int c = 0; c < 10; c++) begin
      if (update_done || busy_out) n_done++;
      @(negedge clk);
    end
    chk("midrst_quiet", n_done, 0);

    // Spawn counter restarted by reset
    run_tick(4'd4, 16'h0321, 8'h11, 1'b0);
    run_tick(4'd4, 16'h0321, 8'h11, 1'b0);
    chk("post_rst_pre_spawn", block_active_out, 0);
    run_tick(4'd4, 16'h0321, 8'h11, 1'b0);
    chk("post_rst_spawn", block_active_out, 4'b0001);
    chk("post_rst_x0", slot_x(0), 1280);
    chk("post_rst_f0", slot_f(0), 16'h0321);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
